// File: rtl/core_gpio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_gpio_pkg                                                        |
// | Register map, port stride and register-select decode for core_gpio.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_gpio_pkg;

    localparam logic [4:0]  c_OFF_OUT      = 5'h00;
    localparam logic [4:0]  c_OFF_OE       = 5'h04;
    localparam logic [4:0]  c_OFF_IN       = 5'h08;
    localparam logic [4:0]  c_OFF_RISE_EN  = 5'h0C;
    localparam logic [4:0]  c_OFF_FALL_EN  = 5'h10;
    localparam logic [4:0]  c_OFF_IRQ_STAT = 5'h14;
    localparam logic [4:0]  c_OFF_OUT_SET  = 5'h18;
    localparam logic [4:0]  c_OFF_OUT_CLR  = 5'h1C;

    localparam logic [31:0] c_PORT_STRIDE  = 32'h20;
    localparam int          c_STRIDE_SHIFT = $clog2(c_PORT_STRIDE);

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_OE,
        SEL_IN,
        SEL_RISE_EN,
        SEL_FALL_EN,
        SEL_IRQ_STAT,
        SEL_OUT_SET,
        SEL_OUT_CLR
    } reg_sel_e;

    // Misaligned byte offsets fall through to SEL_NONE and behave as unmapped.
    function automatic reg_sel_e decode_offset(input logic [4:0] off);
        case (off)
            c_OFF_OUT:      return SEL_OUT;
            c_OFF_OE:       return SEL_OE;
            c_OFF_IN:       return SEL_IN;
            c_OFF_RISE_EN:  return SEL_RISE_EN;
            c_OFF_FALL_EN:  return SEL_FALL_EN;
            c_OFF_IRQ_STAT: return SEL_IRQ_STAT;
            c_OFF_OUT_SET:  return SEL_OUT_SET;
            c_OFF_OUT_CLR:  return SEL_OUT_CLR;
            default:        return SEL_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_gpio_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_gpio_port                                                       |
// | One GPIO port: registers, 2-flop input synchronizer, edge capture.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module core_gpio_port
    import core_gpio_pkg::*;
#(
    parameter int PORT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  reg_sel_e              i_sel,
    input  logic [PORT_WIDTH-1:0] i_wdata,
    input  logic [PORT_WIDTH-1:0] i_wmask,
    input  logic [PORT_WIDTH-1:0] i_pin_in,
    output logic [PORT_WIDTH-1:0] o_rdata,
    output logic [PORT_WIDTH-1:0] o_pin_out,
    output logic [PORT_WIDTH-1:0] o_pin_oe,
    output logic                  o_irq_any
);

    logic [PORT_WIDTH-1:0] r_out;
    logic [PORT_WIDTH-1:0] r_oe;
    logic [PORT_WIDTH-1:0] r_rise_en;
    logic [PORT_WIDTH-1:0] r_fall_en;
    logic [PORT_WIDTH-1:0] r_irq_stat;
    logic [PORT_WIDTH-1:0] r_sync1;
    logic [PORT_WIDTH-1:0] r_sync2;
    logic [PORT_WIDTH-1:0] r_sync_prev;

    logic [PORT_WIDTH-1:0] w_data_m;
    logic [PORT_WIDTH-1:0] w_edges;
    logic [PORT_WIDTH-1:0] w_set;
    logic [PORT_WIDTH-1:0] w_clr;
    logic [PORT_WIDTH-1:0] w_out_wr;
    logic [PORT_WIDTH-1:0] w_w1c;

    function automatic logic [PORT_WIDTH-1:0] merge(
        input logic [PORT_WIDTH-1:0] cur,
        input logic [PORT_WIDTH-1:0] data,
        input logic [PORT_WIDTH-1:0] mask
    );
        return (cur & ~mask) | (data & mask);
    endfunction

    assign w_data_m = i_wdata & i_wmask;
    assign w_edges  = (r_sync2 & ~r_sync_prev & r_rise_en)
                    | (~r_sync2 & r_sync_prev & r_fall_en);
    assign w_set    = (i_wr_en && i_sel == SEL_OUT_SET)  ? w_data_m : '0;
    assign w_clr    = (i_wr_en && i_sel == SEL_OUT_CLR)  ? w_data_m : '0;
    assign w_w1c    = (i_wr_en && i_sel == SEL_IRQ_STAT) ? w_data_m : '0;
    assign w_out_wr = (i_wr_en && i_sel == SEL_OUT) ? merge(r_out, i_wdata, i_wmask) : r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_oe        <= '0;
            r_rise_en   <= '0;
            r_fall_en   <= '0;
            r_irq_stat  <= '0;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_sync_prev <= '0;
        end else begin
            r_sync1     <= i_pin_in;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            // Clear dominates set on OUT; a fresh edge dominates W1C on status.
            r_out       <= (w_out_wr | w_set) & ~w_clr;
            r_irq_stat  <= (r_irq_stat & ~w_w1c) | w_edges;
            if (i_wr_en && i_sel == SEL_OE)      r_oe      <= merge(r_oe, i_wdata, i_wmask);
            if (i_wr_en && i_sel == SEL_RISE_EN) r_rise_en <= merge(r_rise_en, i_wdata, i_wmask);
            if (i_wr_en && i_sel == SEL_FALL_EN) r_fall_en <= merge(r_fall_en, i_wdata, i_wmask);
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_sel)
            SEL_OUT:      o_rdata = r_out;
            SEL_OE:       o_rdata = r_oe;
            SEL_IN:       o_rdata = r_sync2;
            SEL_RISE_EN:  o_rdata = r_rise_en;
            SEL_FALL_EN:  o_rdata = r_fall_en;
            SEL_IRQ_STAT: o_rdata = r_irq_stat;
            default:      o_rdata = '0;
        endcase
    end

    assign o_pin_out = r_out;
    assign o_pin_oe  = r_oe;
    assign o_irq_any = |r_irq_stat;

endmodule
`default_nettype wire

// File: rtl/core_gpio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_gpio                                                            |
// | Multi-port GPIO with single-cycle bus response and edge interrupts.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module core_gpio
    import core_gpio_pkg::*;
#(
    parameter int          NUM_PORTS  = 2,
    parameter int          PORT_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            io_req_valid,
    input  logic [31:0]                     io_req_bits_addrRequest,
    input  logic [31:0]                     io_req_bits_dataRequest,
    input  logic [3:0]                      io_req_bits_activeByteLane,
    input  logic                            io_req_bits_isWrite,
    output logic                            io_rsp_valid,
    output logic [31:0]                     io_rsp_bits_dataResponse,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] io_pin_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] io_pin_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] io_pin_oe,
    output logic                            io_irq
);

    logic [31:0]           w_rel;
    logic [31:0]           w_port_idx;
    logic                  w_in_window;
    reg_sel_e              w_sel;
    logic [31:0]           w_wmask32;
    logic                  w_wr;
    logic [NUM_PORTS-1:0]  w_hit;
    logic [NUM_PORTS-1:0]  w_port_irq;
    logic [PORT_WIDTH-1:0] w_port_rdata [NUM_PORTS];
    logic [31:0]           w_rdata;

    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_data;
    logic                  r_irq;

    assign w_rel       = io_req_bits_addrRequest - BASE_ADDR;
    assign w_port_idx  = w_rel >> c_STRIDE_SHIFT;
    assign w_in_window = (io_req_bits_addrRequest >= BASE_ADDR) && (w_port_idx < 32'(NUM_PORTS));
    assign w_sel       = decode_offset(w_rel[4:0]);
    assign w_wr        = io_req_valid && io_req_bits_isWrite;
    assign w_wmask32   = {{8{io_req_bits_activeByteLane[3]}}, {8{io_req_bits_activeByteLane[2]}},
                          {8{io_req_bits_activeByteLane[1]}}, {8{io_req_bits_activeByteLane[0]}}};

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            assign w_hit[i] = w_in_window && (w_port_idx == 32'(i));

            core_gpio_port #(
                .PORT_WIDTH (PORT_WIDTH)
            ) u_port (
                .clk       (clock),
                .rst_n     (reset),
                .i_wr_en   (w_wr && w_hit[i]),
                .i_sel     (w_sel),
                .i_wdata   (io_req_bits_dataRequest[PORT_WIDTH-1:0]),
                .i_wmask   (w_wmask32[PORT_WIDTH-1:0]),
                .i_pin_in  (io_pin_in[i*PORT_WIDTH +: PORT_WIDTH]),
                .o_rdata   (w_port_rdata[i]),
                .o_pin_out (io_pin_out[i*PORT_WIDTH +: PORT_WIDTH]),
                .o_pin_oe  (io_pin_oe[i*PORT_WIDTH +: PORT_WIDTH]),
                .o_irq_any (w_port_irq[i])
            );
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_hit[i]) w_rdata = w_rdata | 32'(w_port_rdata[i]);
        end
    end

    // Read data is sampled from pre-write state; write responses carry zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_rsp_valid <= io_req_valid;
            r_rsp_data  <= (io_req_valid && !io_req_bits_isWrite) ? w_rdata : '0;
            r_irq       <= |w_port_irq;
        end
    end

    assign io_rsp_valid             = r_rsp_valid;
    assign io_rsp_bits_dataResponse = r_rsp_data;
    assign io_irq                   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_core_gpio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_core_gpio                                                         |
// | Scoreboard bench for core_gpio: default instance and an 8-bit one.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_core_gpio;

    localparam logic [31:0] c_BASE = 32'h4000_0000;
    localparam logic [31:0] c_P1   = 32'h20;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [31:0] exp;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_id = 0;
    exp_t        qa[$];
    exp_t        qb[$];

    logic        a_valid = 1'b0, a_wr = 1'b0;
    logic [31:0] a_addr = '0, a_data = '0;
    logic [3:0]  a_be = '0;
    logic        a_rsp_valid, a_irq;
    logic [31:0] a_rsp_data;
    logic [63:0] a_pin_in = '0, a_pin_out, a_pin_oe;

    logic        b_valid = 1'b0, b_wr = 1'b0;
    logic [31:0] b_addr = '0, b_data = '0;
    logic [3:0]  b_be = '0;
    logic        b_rsp_valid, b_irq;
    logic [31:0] b_rsp_data;
    logic [15:0] b_pin_in = '0, b_pin_out, b_pin_oe;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    core_gpio u_dut_a (
        .clock                      (clk),
        .reset                      (rst_n),
        .io_req_valid               (a_valid),
        .io_req_bits_addrRequest    (a_addr),
        .io_req_bits_dataRequest    (a_data),
        .io_req_bits_activeByteLane (a_be),
        .io_req_bits_isWrite        (a_wr),
        .io_rsp_valid               (a_rsp_valid),
        .io_rsp_bits_dataResponse   (a_rsp_data),
        .io_pin_in                  (a_pin_in),
        .io_pin_out                 (a_pin_out),
        .io_pin_oe                  (a_pin_oe),
        .io_irq                     (a_irq)
    );

    core_gpio #(
        .NUM_PORTS  (2),
        .PORT_WIDTH (8)
    ) u_dut_b (
        .clock                      (clk),
        .reset                      (rst_n),
        .io_req_valid               (b_valid),
        .io_req_bits_addrRequest    (b_addr),
        .io_req_bits_dataRequest    (b_data),
        .io_req_bits_activeByteLane (b_be),
        .io_req_bits_isWrite        (b_wr),
        .io_rsp_valid               (b_rsp_valid),
        .io_rsp_bits_dataResponse   (b_rsp_data),
        .io_pin_in                  (b_pin_in),
        .io_pin_out                 (b_pin_out),
        .io_pin_oe                  (b_pin_oe),
        .io_irq                     (b_irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one request at a falling edge; the request stays on the bus until the next call.
    task automatic bus(input bit on_b, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input bit wr, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        e.cyc = cyc; e.rd = !wr; e.exp = exp; e.id = n_id++;
        if (!on_b) begin
            a_valid = 1'b1; a_addr = addr; a_data = data; a_be = be; a_wr = wr;
            qa.push_back(e);
        end else begin
            b_valid = 1'b1; b_addr = addr; b_data = data; b_be = be; b_wr = wr;
            qb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (a_rsp_valid) begin
            if (qa.size() == 0) chk("a_spurious_rsp", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = qa.pop_front();
                chk($sformatf("a_rsp_latency#%0d", e.id), 32'(cyc - e.cyc), 32'd1);
                if (e.rd) chk($sformatf("a_rdata#%0d", e.id), a_rsp_data, e.exp);
            end
        end else begin
            chk("a_idle_data", a_rsp_data, 32'd0);
            if (qa.size() != 0 && qa[0].cyc + 1 == cyc) begin
                chk($sformatf("a_rsp_missing#%0d", qa[0].id), 32'd0, 32'd1);
                void'(qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (b_rsp_valid) begin
            if (qb.size() == 0) chk("b_spurious_rsp", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = qb.pop_front();
                chk($sformatf("b_rsp_latency#%0d", e.id), 32'(cyc - e.cyc), 32'd1);
                if (e.rd) chk($sformatf("b_rdata#%0d", e.id), b_rsp_data, e.exp);
            end
        end else begin
            chk("b_idle_data", b_rsp_data, 32'd0);
            if (qb.size() != 0 && qb[0].cyc + 1 == cyc) begin
                chk($sformatf("b_rsp_missing#%0d", qb[0].id), 32'd0, 32'd1);
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_pin_out", a_pin_out[31:0], 32'd0);
        chk("reset_pin_oe", a_pin_oe[63:32], 32'd0);
        chk("reset_irq", {31'd0, a_irq}, 32'd0);
        bus(0, c_BASE + 32'h00, 32'h0, 4'hF, 0, 32'h0);
        bus(0, c_BASE + 32'h14, 32'h0, 4'hF, 0, 32'h0);

        // Byte-lane write to OUT, then set/clear aliases and OE.
        bus(0, c_BASE + 32'h00, 32'hA5A5_A5A5, 4'b0011, 1, 32'h0);
        bus(0, c_BASE + 32'h00, 32'h0, 4'hF, 0, 32'h0000_A5A5);
        chk("pin_out_lanes", {16'd0, a_pin_out[15:0]}, 32'h0000_A5A5);
        bus(0, c_BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, 1, 32'h0);
        bus(0, c_BASE + 32'h18, 32'h0F00_0000, 4'hF, 1, 32'h0);
        bus(0, c_BASE + 32'h1C, 32'h0000_0005, 4'hF, 1, 32'h0);
        bus(0, c_BASE + 32'h00, 32'h0, 4'hF, 0, 32'h0F00_A5A0);
        chk("pin_oe_full", a_pin_oe[31:0], 32'hFFFF_FFFF);
        bus(0, c_BASE + 32'h18, 32'h0, 4'hF, 0, 32'h0);
        bus(0, c_BASE + 32'h1C, 32'h0, 4'hF, 0, 32'h0);

        // Port isolation and out-of-window accesses.
        bus(0, c_BASE + c_P1 + 32'h00, 32'h1234_5678, 4'hF, 1, 32'h0);
        bus(0, c_BASE + c_P1 + 32'h00, 32'h0, 4'hF, 0, 32'h1234_5678);
        bus(0, c_BASE + 32'h00, 32'h0, 4'hF, 0, 32'h0F00_A5A0);
        chk("pin_out_p1", a_pin_out[63:32], 32'h1234_5678);
        bus(0, c_BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 1, 32'h0);
        bus(0, c_BASE + 32'h40, 32'h0, 4'hF, 0, 32'h0);
        bus(0, c_BASE - 32'h4, 32'h0, 4'hF, 0, 32'h0);
        bus(0, c_BASE + 32'h08, 32'h0, 4'hF, 0, 32'h0);

        // Rising edge on port1 bit3.
        bus(0, c_BASE + c_P1 + 32'h0C, 32'h8, 4'hF, 1, 32'h0);
        bus(0, c_BASE + 32'h10, 32'h1, 4'hF, 1, 32'h0);
        idle();
        a_pin_in[35] = 1'b1;
        a_pin_in[0]  = 1'b1;
        idle();
        bus(0, c_BASE + c_P1 + 32'h08, 32'h0, 4'hF, 0, 32'h0000_0008);
        chk("irq_before_stat", {31'd0, a_irq}, 32'd0);
        bus(0, c_BASE + c_P1 + 32'h14, 32'h0, 4'hF, 0, 32'h0000_0008);
        chk("irq_lag", {31'd0, a_irq}, 32'd0);
        idle();
        chk("irq_set", {31'd0, a_irq}, 32'd1);
        bus(0, c_BASE + 32'h14, 32'h0, 4'hF, 0, 32'h0);
        bus(0, c_BASE + c_P1 + 32'h14, 32'h8, 4'hF, 1, 32'h0);
        idle();
        idle();
        chk("irq_cleared", {31'd0, a_irq}, 32'd0);
        bus(0, c_BASE + c_P1 + 32'h14, 32'h0, 4'hF, 0, 32'h0);

        // Falling edge on port0 bit0 coincides with W1C of that bit.
        idle();
        a_pin_in[0] = 1'b0;
        idle();
        bus(0, c_BASE + 32'h14, 32'h1, 4'hF, 1, 32'h0);
        bus(0, c_BASE + 32'h14, 32'h0, 4'hF, 0, 32'h1);
        idle();
        chk("irq_set_wins", {31'd0, a_irq}, 32'd1);

        // Narrow instance: bits above PORT_WIDTH vanish, missing port reads zero.
        bus(1, c_BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, 1, 32'h0);
        bus(1, c_BASE + 32'h04, 32'h0, 4'hF, 0, 32'h0000_00FF);
        chk("b_pin_oe", {24'd0, b_pin_oe[7:0]}, 32'h0000_00FF);
        bus(1, c_BASE + 32'h40, 32'h0, 4'hF, 0, 32'h0);
        idle();

        // Reset in the middle of a four-request burst.
        bus(0, c_BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, 1, 32'h0);
        bus(0, c_BASE + 32'h04, 32'h0000_F0F0, 4'hF, 1, 32'h0);
        bus(0, c_BASE + 32'h00, 32'h0, 4'hF, 0, 32'hFFFF_FFFF);
        #2 rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_data", a_rsp_data, 32'd0);
        chk("rst_pin_out", a_pin_out[31:0], 32'd0);
        chk("rst_pin_oe", a_pin_oe[31:0], 32'd0);
        chk("rst_irq", {31'd0, a_irq}, 32'd0);
        @(negedge clk);
        a_addr = c_BASE + 32'h04; a_wr = 1'b0;
        idle();
        rst_n = 1'b1;
        bus(0, c_BASE + 32'h18, 32'h1, 4'hF, 1, 32'h0);
        bus(0, c_BASE + 32'h00, 32'h0, 4'hF, 0, 32'h1);
        chk("set_after_rst", a_pin_out[31:0], 32'h1);
        idle();
        repeat (3) idle();

        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
